// File: rtl/rr_encoder4x2_if.sv
// Request/result bundle for the 4-to-2 event encoder.
// The master drives request lines and out_ready; the slave (encoder) drives the index.
interface rr_encoder4x2_if;
    logic i0;
    logic i1;
    logic i2;
    logic i3;
    logic out_ready;
    logic s1;
    logic s0;
    logic out_valid;
    logic ovf;

    modport master (
        output i0, i1, i2, i3, out_ready,
        input  s1, s0, out_valid, ovf
    );

    modport slave (
        input  i0, i1, i2, i3, out_ready,
        output s1, s0, out_valid, ovf
    );
endinterface

// File: rtl/rr_encoder4x2.sv
// Edge-triggered 4-to-2 event encoder: captures rising edges as pending events and
// issues one binary index per valid/ready transfer, round-robin or fixed priority.
module rr_encoder4x2 #(
    parameter bit RR_EN = 1'b1
) (
    input logic          clk,
    input logic          rst,
    rr_encoder4x2_if.slave bus
);

    logic [3:0] in_vec;
    logic [3:0] rise;
    logic [3:0] cand;
    logic [3:0] sel_mask;
    logic [1:0] sel_idx;
    logic [1:0] probe;
    logic       found;
    logic       load;

    logic [3:0] prev_q, prev_d;
    logic [3:0] pend_q, pend_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;

    assign in_vec = {bus.i3, bus.i2, bus.i1, bus.i0};
    assign rise   = in_vec & ~prev_q;
    assign cand   = pend_q | rise;

    // Round-robin probes ptr+1..ptr+4 (wrapping back to ptr); fixed priority probes 0..3.
    always_comb begin
        sel_idx = 2'd0;
        found   = 1'b0;
        probe   = 2'd0;
        for (int j = 1; j <= 4; j++) begin
            probe = RR_EN ? (ptr_q + 2'(j)) : 2'(j - 1);
            if (!found && cand[probe]) begin
                sel_idx = probe;
                found   = 1'b1;
            end
        end
    end

    assign load     = (~valid_q | bus.out_ready) & (|cand);
    assign sel_mask = load ? (4'b0001 << sel_idx) : 4'b0000;

    always_comb begin
        prev_d  = in_vec;
        pend_d  = cand & ~sel_mask;
        ovf_d   = ovf_q | (|(rise & pend_q & ~sel_mask));
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        if (load) begin
            idx_d   = sel_idx;
            valid_d = 1'b1;
            if (RR_EN) begin
                ptr_d = sel_idx;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pointer resets to 3 so the first round-robin search begins at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 4'b0000;
            pend_q  <= 4'b0000;
            ptr_q   <= 2'd3;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.s1        = idx_q[1];
    assign bus.s0        = idx_q[0];
    assign bus.out_valid = valid_q;
    assign bus.ovf       = ovf_q;

endmodule
